ccu_snoop_responder: RTL
========================

// Module: ccu_snoop_responder
// PURPOSE
//  Snoop-side slave for one cached ACE master: accepts AC snoops from the CCU snoop crossbar,
//  looks up a local tag/state array, returns CR, streams the full line on CD when data moves,
//  then updates line state. Sits between the snoop crossbar and the master's cache arrays.
//  Handles one snoop at a time, in order.
// PARAMETERS
//  ADDR_WIDTH  64  AC address width
//  DATA_WIDTH  64  CD data width
//  LINE_BYTES  64  cache line size; CD_BEATS = LINE_BYTES*8/DATA_WIDTH (localparam, >=1)
// PORTS
//  clk_i            in   1    clock
//  rst_i            in   1    reset; one clock, synchronous, active-high
//  ac_valid_i/ac_ready_o  in/out 1  AC handshake
//  ac_addr_i        in   AW   snoop address
//  ac_snoop_i       in   4    AC snoop opcode
//  ac_prot_i        in   3    accepted, unused
//  cr_valid_o/cr_ready_i  out/in 1  CR handshake
//  cr_resp_o        out  5    {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//  cd_valid_o/cd_ready_i  out/in 1  CD handshake
//  cd_data_o        out  DW   CD beat data
//  cd_last_o        out  1    last CD beat
//  lookup_req_o     out  1    tag lookup strobe
//  lookup_addr_o    out  AW   line-aligned address; held stable until IDLE
//  lookup_hit_i/lookup_dirty_i/lookup_unique_i  in 1  results, valid cycle after lookup_req_o
//  data_req_o       out  1    data array read strobe
//  data_beat_o      out  max(1,clog2(CD_BEATS))  beat index to read
//  data_i           in   DW   read data; valid cycle after data_req_o, held until next data_req_o
//  upd_valid_o      out  1    one-cycle state-update pulse, applies to lookup_addr_o
//  upd_inval_o/upd_clr_dirty_o/upd_clr_unique_o  out 1  update actions
// BEHAVIOUR
//  Reset: state IDLE; all valids/strobes 0; cr_resp_o=0, cd_last_o=0, beat counter 0, regs cleared.
//  Reset mid-transaction abandons it: no CR/CD/update issued afterwards.
//  FSM IDLE->LOOKUP->RESP->[FETCH<->SEND]->UPDATE->IDLE
//   IDLE: ac_ready_o=1. On handshake, latch opcode, latch aligned addr (low log2(LINE_BYTES) bits=0),
//         lookup_req_o=1 same cycle (combinational on handshake) -> LOOKUP.
//   LOOKUP: register hit/dirty/unique, compute resp and actions -> RESP.
//   RESP: cr_valid_o=1, cr_resp_o stable until cr handshake.
//         On handshake: DataTransfer=1 -> FETCH, beat=0; else if any action -> UPDATE; else -> IDLE.
//   FETCH: data_req_o=1, data_beat_o=beat -> SEND.
//   SEND: cd_valid_o=1, cd_data_o=data_i, cd_last_o=(beat==CD_BEATS-1).
//         On handshake: last -> UPDATE (IDLE if no action); else beat++ -> FETCH.
//   UPDATE: upd_valid_o=1 for exactly one cycle -> IDLE.
//  CD never precedes CR. One beat per 2 cycles max. Beats ascend from line offset 0.
//  The update always follows the final CD beat: data is read before invalidation.
//  Response table (miss => resp 0, no data, no update, for every opcode):
//   ReadOnce 0000: DT=1 IS=1 PD=0 WU=unique; no update.
//   ReadShared 0001/ReadClean 0010/ReadNotSharedDirty 0011:
//     DT=1 IS=1 PD=dirty WU=unique; clr_dirty=dirty, clr_unique=1.
//   ReadUnique 0111: DT=1 IS=0 PD=dirty WU=unique; inval.
//   CleanInvalid 1001: DT=PD=dirty IS=0 WU=unique; inval.
//   CleanShared 1000: DT=PD=dirty IS=1 WU=unique; clr_dirty=dirty.
//   MakeInvalid 1101: DT=PD=IS=0 WU=unique; inval.
//   Other opcodes: Error=1, rest 0, no data, no update.
//  Simultaneous ac_valid during a busy period: ac_ready_o=0, request held by sender.
//  Back-to-back snoops: earliest next AC accept is the cycle after return to IDLE.
// TESTING
//  1 ReadShared, hit dirty unique, CD_BEATS=8 -> cr_resp=5'b11101; 8 beats, last on 8th;
//    upd clr_dirty=1 clr_unique=1 after last beat.
//  2 ReadUnique, hit clean shared -> cr_resp=5'b00001; 8 beats; upd inval=1.
//  3 CleanInvalid, hit clean -> cr_resp=0; no CD; upd inval=1 one cycle after CR handshake.
//  4 Any opcode, miss, addr 0x1234 -> lookup_addr_o=0x1200; cr_resp=0; no CD, no upd.
//  5 Opcode 0101 -> cr_resp=5'b00010. cd_ready_i low for 5 cycles on beat 3 -> cd_data/last held,
//    no data_req_o. cr_ready_i low 4 cycles -> resp stable.
//  6 rst_i asserted in SEND beat 2 -> next cycle all valids 0, ac_ready_o=1,
//    no upd pulse; new snoop completes normally.

Source files
------------

// File: rtl/ccu_snoop_responder_if.sv
// ---------------------------------------------------------------------------
// ccu_snoop_responder_if
// Snoop channel bundle between the CCU snoop crossbar (master side) and a
// cached master's snoop responder (slave side). The signal names carry the
// direction as seen from the responder.
//
//   AC : ac_valid_i / ac_ready_o, ac_addr_i, ac_snoop_i, ac_prot_i
//   CR : cr_valid_o / cr_ready_i, cr_resp_o {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   CD : cd_valid_o / cd_ready_i, cd_data_o, cd_last_o
// ---------------------------------------------------------------------------
interface ccu_snoop_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  ac_valid_i;
  logic                  ac_ready_o;
  logic [ADDR_WIDTH-1:0] ac_addr_i;
  logic [3:0]            ac_snoop_i;
  logic [2:0]            ac_prot_i;

  logic                  cr_valid_o;
  logic                  cr_ready_i;
  logic [4:0]            cr_resp_o;

  logic                  cd_valid_o;
  logic                  cd_ready_i;
  logic [DATA_WIDTH-1:0] cd_data_o;
  logic                  cd_last_o;

  // Snoop crossbar side
  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
    input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
  );

  // Responder side
  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, cr_ready_i, cd_ready_i,
    output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
  );
endinterface

// File: rtl/ccu_snoop_responder.sv
// ---------------------------------------------------------------------------
// ccu_snoop_responder
// Snoop-side slave for one cached ACE master. Accepts one AC snoop at a time,
// looks the line up in the local tag/state array, answers on CR, streams the
// whole line on CD when data has to move, and finally issues a single state
// update pulse for the line.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   snp (slave modport)     AC / CR / CD channels
//   lookup_req_o/addr_o     tag lookup strobe and line-aligned address
//   lookup_hit/dirty/unique_i  lookup results, valid the cycle after the strobe
//   data_req_o/data_beat_o  data array read strobe and beat index
//   data_i                  read data, valid the cycle after data_req_o
//   upd_valid_o             one-cycle state update pulse for lookup_addr_o
//   upd_inval_o/upd_clr_dirty_o/upd_clr_unique_o  update actions
// ---------------------------------------------------------------------------
module ccu_snoop_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BYTES = 64,
  localparam int CD_BEATS  = (LINE_BYTES * 8) / DATA_WIDTH,
  localparam int BEAT_W    = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ccu_snoop_responder_if.slave  snp,
  output logic                  lookup_req_o,
  output logic [ADDR_WIDTH-1:0] lookup_addr_o,
  input  logic                  lookup_hit_i,
  input  logic                  lookup_dirty_i,
  input  logic                  lookup_unique_i,
  output logic                  data_req_o,
  output logic [BEAT_W-1:0]     data_beat_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  upd_valid_o,
  output logic                  upd_inval_o,
  output logic                  upd_clr_dirty_o,
  output logic                  upd_clr_unique_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESP,
    FETCH,
    SEND,
    UPDATE
  } state_t;

  state_t                state_q;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [4:0]            resp_q;
  logic                  inval_q;
  logic                  clr_dirty_q;
  logic                  clr_unique_q;
  logic                  cr_valid_q;
  logic                  cd_valid_q;
  logic                  cd_last_q;
  logic                  data_req_q;
  logic                  upd_valid_q;

  logic                  ac_ready;
  logic                  ac_hs;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  last_beat;
  logic                  any_action;

  logic                  wu;
  logic                  is_shared;
  logic                  pass_dirty;
  logic                  err;
  logic                  dt;
  logic                  inval_d;
  logic                  clr_dirty_d;
  logic                  clr_unique_d;

  // The protection attributes carry no meaning for this responder.
  logic                  unused_prot;
  assign unused_prot = ^snp.ac_prot_i;

  // Ready is withheld while reset is asserted so a snoop presented in the
  // reset cycle is not silently swallowed.
  assign ac_ready     = (state_q == IDLE) && !rst_i;
  assign ac_hs        = snp.ac_valid_i && ac_ready;
  assign aligned_addr = snp.ac_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);

  assign snp.ac_ready_o = ac_ready;
  assign snp.cr_valid_o = cr_valid_q;
  assign snp.cr_resp_o  = resp_q;
  assign snp.cd_valid_o = cd_valid_q;
  assign snp.cd_data_o  = data_i;
  assign snp.cd_last_o  = cd_last_q;

  // The lookup fires in the accept cycle, so the address follows the AC bus
  // while idle and the latched copy for the rest of the transaction.
  assign lookup_req_o  = ac_hs;
  assign lookup_addr_o = (state_q == IDLE) ? aligned_addr : addr_q;

  assign data_req_o       = data_req_q;
  assign data_beat_o      = beat_q;
  assign upd_valid_o      = upd_valid_q;
  assign upd_inval_o      = inval_q;
  assign upd_clr_dirty_o  = clr_dirty_q;
  assign upd_clr_unique_o = clr_unique_q;

  assign last_beat  = (beat_q == BEAT_W'(CD_BEATS - 1));
  assign any_action = inval_q || clr_dirty_q || clr_unique_q;

  // Snoop response and line-state actions from the latched opcode and the
  // lookup result. A miss answers all zeros whatever the opcode.
  always_comb begin
    wu           = 1'b0;
    is_shared    = 1'b0;
    pass_dirty   = 1'b0;
    err          = 1'b0;
    dt           = 1'b0;
    inval_d      = 1'b0;
    clr_dirty_d  = 1'b0;
    clr_unique_d = 1'b0;
    if (lookup_hit_i) begin
      wu = lookup_unique_i;
      case (op_q)
        4'b0000: begin
          dt        = 1'b1;
          is_shared = 1'b1;
        end
        4'b0001, 4'b0010, 4'b0011: begin
          dt           = 1'b1;
          is_shared    = 1'b1;
          pass_dirty   = lookup_dirty_i;
          clr_dirty_d  = lookup_dirty_i;
          clr_unique_d = 1'b1;
        end
        4'b0111: begin
          dt         = 1'b1;
          pass_dirty = lookup_dirty_i;
          inval_d    = 1'b1;
        end
        4'b1001: begin
          dt         = lookup_dirty_i;
          pass_dirty = lookup_dirty_i;
          inval_d    = 1'b1;
        end
        4'b1000: begin
          dt          = lookup_dirty_i;
          pass_dirty  = lookup_dirty_i;
          is_shared   = 1'b1;
          clr_dirty_d = lookup_dirty_i;
        end
        4'b1101: begin
          inval_d = 1'b1;
        end
        default: begin
          wu  = 1'b0;
          err = 1'b1;
        end
      endcase
    end
  end

  // Transaction sequencer. Data always leaves before the state update so a
  // dirty line is never invalidated ahead of its last CD beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      beat_q       <= '0;
      resp_q       <= '0;
      inval_q      <= 1'b0;
      clr_dirty_q  <= 1'b0;
      clr_unique_q <= 1'b0;
      cr_valid_q   <= 1'b0;
      cd_valid_q   <= 1'b0;
      cd_last_q    <= 1'b0;
      data_req_q   <= 1'b0;
      upd_valid_q  <= 1'b0;
    end else begin
      data_req_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ac_hs) begin
            op_q    <= snp.ac_snoop_i;
            addr_q  <= aligned_addr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_q       <= {wu, is_shared, pass_dirty, err, dt};
          inval_q      <= inval_d;
          clr_dirty_q  <= clr_dirty_d;
          clr_unique_q <= clr_unique_d;
          cr_valid_q   <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (snp.cr_ready_i) begin
            cr_valid_q <= 1'b0;
            if (resp_q[0]) begin
              beat_q     <= '0;
              data_req_q <= 1'b1;
              state_q    <= FETCH;
            end else if (any_action) begin
              upd_valid_q <= 1'b1;
              state_q     <= UPDATE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FETCH: begin
          cd_valid_q <= 1'b1;
          cd_last_q  <= last_beat;
          state_q    <= SEND;
        end
        SEND: begin
          if (snp.cd_ready_i) begin
            cd_valid_q <= 1'b0;
            cd_last_q  <= 1'b0;
            if (cd_last_q) begin
              if (any_action) begin
                upd_valid_q <= 1'b1;
                state_q     <= UPDATE;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              beat_q     <= beat_q + 1'b1;
              data_req_q <= 1'b1;
              state_q    <= FETCH;
            end
          end
        end
        UPDATE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
